// File: rtl/debouncer_multi_if.sv
// -----------------------------------------------------------------------------
// debouncer_multi_if
//   Groups the switch-side and control-side signals of debouncer_multi.
//   Clock and reset are not part of the bundle; they stay plain module ports.
//
//   SwIn       raw asynchronous switch inputs          (master -> slave)
//   SwOutDB    debounced levels                        (slave -> master)
//   RisePulse  one-cycle strobe on a 0->1 debounced edge
//   FallPulse  one-cycle strobe on a 1->0 debounced edge
//   AnyChange  OR of all rise/fall strobes, same cycle
//   LongPress  one-cycle long-press strobe (zero unless the feature is built)
//
//   Modports: master = whoever drives the switches and consumes the results,
//             slave  = the debouncer itself.
// -----------------------------------------------------------------------------
interface debouncer_multi_if #(
    parameter int N = 4
);
    logic [N-1:0] SwIn;
    logic [N-1:0] SwOutDB;
    logic [N-1:0] RisePulse;
    logic [N-1:0] FallPulse;
    logic         AnyChange;
    logic [N-1:0] LongPress;

    modport master (
        output SwIn,
        input  SwOutDB, RisePulse, FallPulse, AnyChange, LongPress
    );

    modport slave (
        input  SwIn,
        output SwOutDB, RisePulse, FallPulse, AnyChange, LongPress
    );
endinterface

// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
//   N independent switch debouncers. Each channel runs its raw input through a
//   2-FF synchroniser, then a stability counter: the debounced level only
//   flips after STABLE_CNT consecutive samples that disagree with it. Any
//   agreeing sample throws the partial count away.
//
//   Optional feature macro: DEBOUNCE_LONG_PRESS_EN
//     Defined   : per-channel held counter, LongPress[i] pulses once when the
//                 debounced level has been high for LONG_CNT cycles.
//     Undefined : no held counters, LongPress tied low. Port list unchanged.
//
//   Ports
//     Clk1ms  sampling clock, all logic on its rising edge
//     Rst     asynchronous active-high reset
//     bus     debouncer_multi_if.slave (SwIn in; SwOutDB, RisePulse,
//             FallPulse, AnyChange, LongPress out)
// -----------------------------------------------------------------------------
module debouncer_multi #(
    parameter int   N          = 4,
    parameter int   STABLE_CNT = 4,
    parameter logic RST_VAL    = 1'b0,
    parameter int   LONG_CNT   = 1000
) (
    input  logic                Clk1ms,
    input  logic                Rst,
    debouncer_multi_if.slave    bus
);
    localparam int CW = $clog2(STABLE_CNT + 1);

    // Elaboration-time sanity checks on the configuration.
    if (N < 1)          $error("debouncer_multi: N must be >= 1");
    if (STABLE_CNT < 1) $error("debouncer_multi: STABLE_CNT must be >= 1");
    if (LONG_CNT < 1)   $error("debouncer_multi: LONG_CNT must be >= 1");

    logic [N-1:0]         s1_q, s2_q;
    logic [N-1:0]         db_q, db_d;
    logic [N-1:0]         rise_q, rise_d;
    logic [N-1:0]         fall_q, fall_d;
    logic                 any_q, any_d;
    logic [N-1:0][CW-1:0] cnt_q, cnt_d;

    // Per-channel stability counter. Because the count restarts on every
    // agreeing sample and the update happens at STABLE_CNT-1, cnt never
    // exceeds STABLE_CNT-1.
    always_comb begin
        db_d   = db_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < N; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(STABLE_CNT - 1)) begin
                db_d[i]   = s2_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = s2_q[i];
                fall_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge Clk1ms or posedge Rst) begin
        if (Rst) begin
            s1_q   <= {N{RST_VAL}};
            s2_q   <= {N{RST_VAL}};
            db_q   <= {N{RST_VAL}};
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
        end else begin
            s1_q   <= bus.SwIn;
            s2_q   <= s1_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
        end
    end

    assign bus.SwOutDB   = db_q;
    assign bus.RisePulse = rise_q;
    assign bus.FallPulse = fall_q;
    assign bus.AnyChange = any_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CNT + 1);

    logic [N-1:0][LW-1:0] held_q, held_d;
    logic [N-1:0]         lp_q, lp_d;

    // Held counter follows the registered debounced level, so counting
    // starts the cycle after the rise strobe and the pulse lands LONG_CNT
    // cycles after it. Saturation at LONG_CNT gives one pulse per press.
    always_comb begin
        held_d = held_q;
        lp_d   = '0;
        for (int i = 0; i < N; i++) begin
            if (!db_q[i]) begin
                held_d[i] = '0;
            end else if (held_q[i] != LW'(LONG_CNT)) begin
                held_d[i] = held_q[i] + LW'(1);
                lp_d[i]   = (held_q[i] == LW'(LONG_CNT - 1));
            end
        end
    end

    always_ff @(posedge Clk1ms or posedge Rst) begin
        if (Rst) begin
            held_q <= '0;
            lp_q   <= '0;
        end else begin
            held_q <= held_d;
            lp_q   <= lp_d;
        end
    end

    assign bus.LongPress = lp_q;
`else
    assign bus.LongPress = '0;
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// -----------------------------------------------------------------------------
// tb_debouncer_multi
//   Directed stimulus for debouncer_multi. Each stimulus step pushes the
//   strobe event it should cause (cycle, level, rise, fall) into a queue; an
//   independent monitor pops and compares whenever the DUT shows a strobe.
// -----------------------------------------------------------------------------
module tb_debouncer_multi;
    localparam int N  = 4;
    localparam int SC = 4;
    localparam int LC = 10;

    logic Clk1ms = 1'b0;
    logic Rst    = 1'b1;

    debouncer_multi_if #(.N(N)) bus ();

    debouncer_multi #(
        .N(N), .STABLE_CNT(SC), .RST_VAL(1'b0), .LONG_CNT(LC)
    ) dut (
        .Clk1ms (Clk1ms),
        .Rst    (Rst),
        .bus    (bus.slave)
    );

    always #5 Clk1ms = ~Clk1ms;

    // Free-running edge count; an event expected "at edge k" is visible at
    // the falling edge where cyc == k.
    int cyc = 0;
    always @(posedge Clk1ms) cyc++;

    typedef struct {
        int           at;
        logic [N-1:0] db;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } ev_t;

    ev_t          evq[$];
    int           lpq_at[$];
    logic [N-1:0] lpq_mask[$];
    logic [N-1:0] db_model = '0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0h expected nothing (cycle %0d)", nm, act, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    always @(negedge Clk1ms) begin
        if (!Rst) begin
            if (bus.AnyChange || (|bus.RisePulse) || (|bus.FallPulse)) begin
                if (evq.size() == 0) begin
                    fail_now("unexpected_strobe", {bus.AnyChange, bus.RisePulse, bus.FallPulse});
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("strobe_cycle", cyc, e.at);
                    chk("sw_out_db", bus.SwOutDB, e.db);
                    chk("rise_pulse", bus.RisePulse, e.rise);
                    chk("fall_pulse", bus.FallPulse, e.fall);
                    chk("any_change", bus.AnyChange, 1);
                end
            end
            if (|bus.LongPress) begin
                if (lpq_at.size() == 0) begin
                    fail_now("unexpected_long_press", bus.LongPress);
                end else begin
                    chk("long_press_cycle", cyc, lpq_at.pop_front());
                    chk("long_press_mask", bus.LongPress, lpq_mask.pop_front());
                end
            end
        end
    end

    // Drive SwIn on a falling edge; returns the rising edge that samples it.
    task automatic set_in(input logic [N-1:0] v, output int e);
        @(negedge Clk1ms);
        bus.SwIn = v;
        e = cyc + 1;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge Clk1ms);
    endtask

    // Expected result of holding v from sampling edge e long enough to settle.
    task automatic expect_settle(input logic [N-1:0] v, input int e, input logic long_hold);
        ev_t          x;
        logic [N-1:0] ch;
        ch = v ^ db_model;
        if (ch != '0) begin
            x.at   = e + 1 + SC;
            x.db   = v;
            x.rise = v & ch;
            x.fall = ~v & ch;
            evq.push_back(x);
            db_model = v;
`ifdef DEBOUNCE_LONG_PRESS_EN
            if (long_hold && (x.rise != '0)) begin
                lpq_at.push_back(x.at + LC);
                lpq_mask.push_back(x.rise);
            end
`else
            if (long_hold) ;
`endif
        end
    endtask

    task automatic drain(input int max_cyc);
        int k;
        k = 0;
        while (evq.size() != 0 || lpq_at.size() != 0) begin
            @(negedge Clk1ms);
            k++;
            if (k > max_cyc) begin
                fail_now("drain_timeout", evq.size() + lpq_at.size());
                evq.delete();
                lpq_at.delete();
                lpq_mask.delete();
                break;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic long_hold);
        int e;
        set_in(v, e);
        expect_settle(v, e, long_hold);
        if (long_hold) idle(LC + 10);
        drain(40);
    endtask

    initial begin
        int e;
        bus.SwIn = '0;

        // Reset state
        idle(3);
        chk("rst_sw_out_db", bus.SwOutDB, 0);
        chk("rst_rise", bus.RisePulse, 0);
        chk("rst_fall", bus.FallPulse, 0);
        chk("rst_any", bus.AnyChange, 0);
        chk("rst_long", bus.LongPress, 0);
        @(negedge Clk1ms);
        Rst = 1'b0;
        idle(3);

        // Clean press and release on channel 0
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);

        // Glitch rejection on channel 1: 3 high samples never make it through
        for (int r = 0; r < 5; r++) begin
            set_in(4'b0010, e);
            idle(2);
            set_in(4'b0000, e);
            idle(1);
        end
        idle(10);
        chk("glitch_sw_out_db", bus.SwOutDB, 0);

        // Bounce on channel 2: high 3, low 1, then held high
        set_in(4'b0100, e);
        idle(2);
        set_in(4'b0000, e);
        set_in(4'b0100, e);
        expect_settle(4'b0100, e, 1'b0);
        drain(40);
        step(4'b0000, 1'b0);

        // All channels together, release, then re-press
        step(4'b1111, 1'b0);
        step(4'b0000, 1'b0);
        idle(4);
        step(4'b1111, 1'b0);
        step(4'b0000, 1'b0);

        // Long hold on channel 3, release, then re-armed second press
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b0);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b0);

        // Reset in the middle of a pending fall
        step(4'b0001, 1'b0);
        set_in(4'b0000, e);
        idle(2);
        #2 Rst = 1'b1;
        #1;
        chk("midrst_sw_out_db", bus.SwOutDB, 0);
        chk("midrst_rise", bus.RisePulse, 0);
        chk("midrst_any", bus.AnyChange, 0);
        db_model = '0;
        bus.SwIn = 4'b0001;
        idle(2);
        Rst = 1'b0;
        e = cyc + 1;
        expect_settle(4'b0001, e, 1'b0);
        drain(40);
        step(4'b0000, 1'b0);

        idle(5);
        chk("evq_empty", evq.size(), 0);
        chk("lpq_empty", lpq_at.size(), 0);
        chk("final_sw_out_db", bus.SwOutDB, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got cycle %0d expected end of test", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Parametrised, multi-channel successor to the single-switch debouncer.
- Takes N raw switch/button inputs and passes each through a 2-FF synchroniser and a per-channel programmable stability counter.
- Outputs per channel: a debounced level, plus one-cycle rise and fall strobes. Channels are fully independent.
- Sits between board switch pins and the lab control logic, clocked by the 1 ms tick clock.

Parameters:
- N, 4, number of independent channels (>=1).
- STABLE_CNT, 4, consecutive differing samples required before the debounced level changes (>=1).
- RST_VAL, 1'b0, reset value of synchroniser stages and debounced outputs; applies to all channels.
- LONG_CNT, 1000, cycles the debounced level must stay high before LongPress fires (>=1). Used only with the optional feature.

Ports:
- Clk1ms  input  1  sampling clock; all logic on its rising edge.
- Rst  input  1  asynchronous, active-high reset.
- SwIn  input  N  raw, asynchronous switch inputs.
- SwOutDB  output  N  debounced levels.
- RisePulse  output  N  one-cycle strobe when SwOutDB[i] goes 0->1.
- FallPulse  output  N  one-cycle strobe when SwOutDB[i] goes 1->0.
- AnyChange  output  1  OR of all RisePulse and FallPulse bits, registered in the same cycle as them.
- LongPress  output  N  one-cycle long-press strobe (see Optional Feature).

Behaviour:
- Interface: one clock, Clk1ms. Reset Rst is asynchronous and active-high.
- Reset (while Rst=1, asynchronous):
  - Both sync stages and SwOutDB go to RST_VAL.
  - Stability counters and long-press counters go to 0.
  - RisePulse, FallPulse, AnyChange and LongPress go to 0.
  - No strobe fires on reset release, even if SwIn differs from RST_VAL. A normal debounced transition follows after the full latency.
- Synchroniser: s1[i] <= SwIn[i]; s2[i] <= s1[i]. Only s2 feeds the debounce logic.
- Stability counter, per channel, width CW = $clog2(STABLE_CNT+1). On each edge:
  - If s2[i] == SwOutDB[i]: cnt[i] <= 0. No change.
  - Else if cnt[i] == STABLE_CNT-1: SwOutDB[i] <= s2[i]; cnt[i] <= 0; assert the matching Rise/Fall strobe for exactly one cycle.
  - Else: cnt[i] <= cnt[i]+1.
- Net effect: SwOutDB changes only after STABLE_CNT consecutive edges in which s2 differs from it. Any agreeing sample restarts the count, so there is no partial credit across glitches.
- Latency: SwIn stable at a new value from sampling edge E -> SwOutDB and strobe update at edge E+1+STABLE_CNT, visible after that edge.
  - STABLE_CNT=1 gives the fastest response: 2 edges.
- Strobes are registered and coincide with the cycle in which the new SwOutDB value first appears. RisePulse[i] and FallPulse[i] are never high together.
- AnyChange is registered: it equals the OR of the strobes computed on the same edge, so it is aligned with them.
- Simultaneous events: channels update in the same cycle independently, and AnyChange asserts once.
- Reset mid-count: the counter clears, and the debounce must restart from zero after release.
- Counters never exceed STABLE_CNT-1, so no wrap-around is possible.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Each channel gets a held counter, width $clog2(LONG_CNT+1). It clears whenever SwOutDB[i]==0 and increments while SwOutDB[i]==1.
  - LongPress[i] pulses for one cycle on the edge where the count reaches LONG_CNT.
  - The counter then saturates at LONG_CNT, so there is one pulse per press.
  - A fall, or Rst, re-arms the channel.
  - The count starts on the cycle after the RisePulse. LongPress fires LONG_CNT cycles after the rise.
- Undefined: no held counters are built, and LongPress is tied to all zeros. The port list is identical in both builds.

Test Plan:
1. Reset behaviour: N=4, STABLE_CNT=4, RST_VAL=0, SwIn=4'b0000 -> after Rst pulse, SwOutDB=0000 and all strobes 0; holding Rst=1 mid-count clears state immediately.
2. Clean press: SwIn[0] 0->1 held (first sampled at edge E) -> SwOutDB[0]=1 and RisePulse[0]=1 for one cycle at edge E+5, AnyChange=1 same cycle, other channels unchanged.
3. Glitch rejection: SwIn[1] high for 3 cycles then low, repeated 5 times -> SwOutDB[1] stays 0, no strobes.
4. Restart on bounce: SwIn[2] high 3 cycles, low 1, high held -> rise occurs 5 edges after the final rising sample, not earlier.
5. Simultaneous channels: SwIn 0000->1111 on one edge, then later 1111->0000 -> all RisePulse bits together, AnyChange once; later all FallPulse bits together, with 4 cycles between release and re-press honoured.
6. With DEBOUNCE_LONG_PRESS_EN, LONG_CNT=10: hold SwIn[3]=1 -> LongPress[3] single pulse 10 cycles after RisePulse[3], none thereafter; release and re-press re-arms. Without macro, LongPress==0 throughout.
